marsohod2_reset_ctrl: RTL and testbench

Board-level reset sequencer that generates the active-high `soc_reset` driving the vscale Wishbone SoC's `reset` input on the Marsohod2 board. It combines three reset sources, waits for them to settle, and stretches the resulting reset before releasing the core:

- PLL lock status,
- the debounced KEY1 push-button,
- a software reset request from the SoC.

It also reports the cause of the last reset and how many resets have occurred, for the LEDs or a status register.

---
 rtl/marsohod2_reset_pkg.sv | 28 ++
 rtl/reset_debounce.sv | 58 +++++
 rtl/marsohod2_reset_ctrl.sv | 135 +++++++++++++
 tb/tb_marsohod2_reset_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/marsohod2_reset_pkg.sv
`default_nettype none
// ============================================================================
// Module   : marsohod2_reset_pkg
// Brief    : Shared types and constants for the Marsohod2 reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package marsohod2_reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STRETCH   = 2'd1,
        RUN       = 2'd2
    } state_e;

    localparam logic [1:0] CAUSE_POR = 2'd0;
    localparam logic [1:0] CAUSE_PLL = 2'd1;
    localparam logic [1:0] CAUSE_KEY = 2'd2;
    localparam logic [1:0] CAUSE_SW  = 2'd3;

    localparam logic [7:0] COUNT_MAX = 8'hFF;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_debounce.sv
`default_nettype none
// ============================================================================
// Module   : reset_debounce
// Brief    : Two-flop synchronizer and stability counter for the raw KEY1 input.
// Revision : 1.0 - initial release
// ============================================================================
module reset_debounce
    import marsohod2_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key_n,
    output logic key_db
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_meta_q;
    logic             key_s_q;
    logic             key_db_q;
    logic             key_db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any sample that agrees with the debounced level restarts the stability window.
    always_comb begin
        key_db_d = key_db_q;
        cnt_d    = '0;
        if (key_s_q != key_db_q) begin
            if (cnt_q == CNT_LAST) begin
                key_db_d = key_s_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_meta_q <= 1'b1;
            key_s_q    <= 1'b1;
            key_db_q   <= 1'b1;
            cnt_q      <= '0;
        end else begin
            key_meta_q <= key_n;
            key_s_q    <= key_meta_q;
            key_db_q   <= key_db_d;
            cnt_q      <= cnt_d;
        end
    end

    assign key_db = key_db_q;

endmodule
`default_nettype wire

// File: rtl/marsohod2_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : marsohod2_reset_ctrl
// Brief    : Board reset sequencer: PLL lock, KEY1 and software sources, stretched SoC reset.
// Revision : 1.0 - initial release
// ============================================================================
module marsohod2_reset_ctrl
    import marsohod2_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int STRETCH_CYCLES  = 256
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       key_n,
    input  logic       sw_reset_req,
    output logic       soc_reset,
    output logic [1:0] reset_cause,
    output logic [7:0] reset_count
);

    localparam int               CNT_W    = cnt_width(STRETCH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STRETCH_CYCLES - 1);

    logic             lock_meta_q;
    logic             lock_s_q;
    logic             key_db;
    logic             pressed;
    logic             run_exit;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             soc_reset_q;
    logic             soc_reset_d;
    logic [1:0]       cause_q;
    logic [1:0]       cause_d;
    logic [7:0]       count_q;
    logic [7:0]       count_d;

    reset_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock   (clock),
        .reset_n (reset_n),
        .key_n   (key_n),
        .key_db  (key_db)
    );

    assign pressed = !key_db;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cause_d  = cause_q;
        count_d  = count_q;
        run_exit = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s_q) begin
                    state_d = STRETCH;
                end
            end
            STRETCH: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                    cause_d = CAUSE_PLL;
                    cnt_d   = '0;
                end else if (pressed) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_s_q) begin
                    state_d  = WAIT_LOCK;
                    cause_d  = CAUSE_PLL;
                    run_exit = 1'b1;
                end else if (pressed) begin
                    state_d  = STRETCH;
                    cause_d  = CAUSE_KEY;
                    run_exit = 1'b1;
                end else if (sw_reset_req) begin
                    state_d  = STRETCH;
                    cause_d  = CAUSE_SW;
                    run_exit = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        if (run_exit && (count_q != COUNT_MAX)) begin
            count_d = count_q + 8'd1;
        end

        // Registering the next-state decode keeps soc_reset glitch-free.
        soc_reset_d = (state_d != RUN);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            soc_reset_q <= 1'b1;
            cause_q     <= CAUSE_POR;
            count_q     <= 8'd0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_s_q    <= lock_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            soc_reset_q <= soc_reset_d;
            cause_q     <= cause_d;
            count_q     <= count_d;
        end
    end

    assign soc_reset   = soc_reset_q;
    assign reset_cause = cause_q;
    assign reset_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_marsohod2_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_marsohod2_reset_ctrl
// Brief    : Directed plus randomized self-checking bench for marsohod2_reset_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_marsohod2_reset_ctrl;

    localparam int D = 4;
    localparam int S = 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       key_n;
    logic       sw_reset_req;
    logic       soc_reset;
    logic [1:0] reset_cause;
    logic [7:0] reset_count;

    int total = 0;
    int bad   = 0;
    int exp_count;

    marsohod2_reset_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .STRETCH_CYCLES  (S)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .key_n        (key_n),
        .sw_reset_req (sw_reset_req),
        .soc_reset    (soc_reset),
        .reset_cause  (reset_cause),
        .reset_count  (reset_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Edges until soc_reset reaches val; -1 when the budget runs out.
    task automatic wait_soc(input logic val, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (soc_reset === val) begin
                n = i;
                break;
            end
        end
    endtask

    function automatic int sat_inc(input int c);
        return (c >= 255) ? 255 : c + 1;
    endfunction

    task automatic check_status(input string tag, input int cause);
        check({tag, "_cause"}, {30'd0, reset_cause}, cause);
        check({tag, "_count"}, {24'd0, reset_count}, exp_count);
    endtask

    initial begin
        int n;
        int k;
        logic flag;

        reset_n      = 1'b0;
        pll_locked   = 1'b0;
        key_n        = 1'b1;
        sw_reset_req = 1'b0;
        exp_count    = 0;

        // Reset values
        tick(); tick();
        check("por_soc", {31'd0, soc_reset}, 1);
        check_status("por", 0);

        // Power-up release: S+3 edges from first sampled lock
        reset_n = 1'b1;
        tick(); tick();
        check("wait_lock_soc", {31'd0, soc_reset}, 1);
        pll_locked = 1'b1;
        wait_soc(1'b0, 40, n);
        check("powerup_latency", n, S + 3);
        check_status("powerup", 0);

        // Software reset: latency 1, high for S cycles
        tick(); tick();
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        check("sw_latency", {31'd0, soc_reset}, 1);
        exp_count = sat_inc(exp_count);
        wait_soc(1'b0, 40, n);
        check("sw_stretch", n, S);
        check_status("sw", 3);

        // Random glitches shorter than D never reach the core
        for (int p = 0; p < 5; p++) begin
            flag = 1'b0;
            key_n = 1'b0;
            k = $urandom_range(1, D - 1);
            for (int i = 0; i < k; i++) begin
                tick();
                if (soc_reset !== 1'b0) flag = 1'b1;
            end
            key_n = 1'b1;
            k = $urandom_range(2, 6);
            for (int i = 0; i < k + 3; i++) begin
                tick();
                if (soc_reset !== 1'b0) flag = 1'b1;
            end
            check("glitch_no_reset", {31'd0, flag}, 0);
        end

        // Held key: acts at D+2, reset at D+3; held reset; release S after debounced release
        key_n = 1'b0;
        wait_soc(1'b1, 40, n);
        check("key_latency", n, D + 3);
        exp_count = sat_inc(exp_count);
        flag = 1'b0;
        for (int i = 0; i < 20 - (D + 3); i++) begin
            tick();
            if (soc_reset !== 1'b1) flag = 1'b1;
        end
        check("key_held", {31'd0, flag}, 0);
        key_n = 1'b1;
        wait_soc(1'b0, 60, n);
        check("key_release", n, D + 2 + S);
        check_status("key", 2);

        // Lock loss in RUN
        tick();
        pll_locked = 1'b0;
        wait_soc(1'b1, 20, n);
        check("pll_loss_latency", n, 3);
        exp_count = sat_inc(exp_count);
        check_status("pll_run", 1);
        tick(); tick();

        // Relock, then lose lock again at a random point inside STRETCH
        pll_locked = 1'b1;
        k = $urandom_range(3, 8);
        for (int i = 0; i < k; i++) tick();
        pll_locked = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (soc_reset !== 1'b1) flag = 1'b1;
        end
        check("pll_stretch_held", {31'd0, flag}, 0);
        check_status("pll_stretch", 1);
        pll_locked = 1'b1;
        wait_soc(1'b0, 40, n);
        check("relock_latency", n, S + 3);

        // Lock loss and software request seen on the same edge: lock wins
        tick();
        pll_locked = 1'b0;
        tick(); tick();
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        check("simul_soc", {31'd0, soc_reset}, 1);
        exp_count = sat_inc(exp_count);
        check_status("simul", 1);
        tick();
        pll_locked = 1'b1;
        wait_soc(1'b0, 40, n);
        check("simul_relock", n, S + 3);

        // Asynchronous reset mid-STRETCH
        tick();
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        exp_count = sat_inc(exp_count);
        check_status("pre_async", 3);
        tick(); tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_soc", {31'd0, soc_reset}, 1);
        exp_count = 0;
        check_status("async", 0);
        #1;
        reset_n = 1'b1;
        wait_soc(1'b0, 40, n);
        check("after_async_latency", n, S + 3);

        // Random software resets drive the count to saturation
        for (int r = 0; r < 300; r++) begin
            k = $urandom_range(0, 3);
            for (int i = 0; i < k; i++) tick();
            sw_reset_req = 1'b1;
            tick();
            sw_reset_req = 1'b0;
            exp_count = sat_inc(exp_count);
            wait_soc(1'b0, 40, n);
            check("rand_sw_stretch", n, S);
            if (r % 50 == 0) check_status("rand_sw", 3);
        end
        check_status("saturate", 3);
        check("saturate_value", {24'd0, reset_count}, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
